// File: rtl/cpu_multicycle.sv
// Multi-cycle core for the 16-bit instruction set, fetching and loading/storing over one req/ack bus.
// Define CPU_MUL_EN to make opcode D a multiply; without it opcode D retires as a NOP.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | one settling cycle after reset before the first fetch
// S_FETCH  | bus read at pc; instruction register loads on ack
// S_DECODE | read rs/rt operands; HALT is caught here
// S_EXEC   | ALU result or effective address, next-pc selection
// S_MEM    | LW/SW bus access at the ALU address; load data lands on ack
// S_WB     | single register write, pc update, retire pulse
// S_HALTED | absorbing; only pc_reset leaves it
module cpu_multicycle #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              pc_reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              instr_retired,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_BL   = 4'hB;
    localparam logic [3:0] OP_BR   = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t            state_q, state_d;
    logic              idle_wait_q, idle_wait_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [ADDR_W-1:0] npc_q, npc_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic [3:0]        opcode, rs, rt, rd;
    logic [DATA_W-1:0] imm4_d;
    logic [ADDR_W-1:0] imm4_a, imm8_a;
    logic [ADDR_W-1:0] pc_plus_1, jmp_pc;
    logic              is_store, is_mem;
    logic              wr_en;
    logic [3:0]        wr_idx;

    assign opcode    = ir_q[15:12];
    assign rs        = ir_q[11:8];
    assign rt        = ir_q[7:4];
    assign rd        = ir_q[3:0];
    assign imm4_d    = {{(DATA_W-4){ir_q[3]}}, ir_q[3:0]};
    assign imm4_a    = {{(ADDR_W-4){ir_q[3]}}, ir_q[3:0]};
    assign imm8_a    = {{(ADDR_W-8){ir_q[11]}}, ir_q[11:4]};
    assign pc_plus_1 = pc_q + ADDR_W'(1);
    assign is_store  = (opcode == OP_SW);
    assign is_mem    = (opcode == OP_LW) || is_store;

`ifdef CPU_MUL_EN
    logic [DATA_W-1:0] mul_lo;
    assign mul_lo = a_q * b_q;
`endif

    // JMP keeps the page bits of pc+1 and replaces the low 12 bits
    always_comb begin
        jmp_pc        = pc_plus_1;
        jmp_pc[11:0]  = ir_q[11:0];
    end

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = rd;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_BL: wr_en = 1'b1;
            OP_ADDI, OP_LW: begin
                wr_en  = 1'b1;
                wr_idx = rt;
            end
`ifdef CPU_MUL_EN
            OP_MUL: wr_en = 1'b1;
`endif
            default: wr_en = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idle_wait_d = idle_wait_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        npc_d       = npc_q;
        regs_d      = regs_q;

        case (state_q)
            S_IDLE: begin
                if (idle_wait_q) idle_wait_d = 1'b0;
                else             state_d     = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata[15:0];
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = regs_q[rs];
                b_d     = regs_q[rt];
                state_d = (opcode == OP_HALT) ? S_HALTED : S_EXEC;
            end
            S_EXEC: begin
                npc_d = pc_plus_1;
                res_d = '0;
                case (opcode)
                    OP_ADD:  res_d = a_q + b_q;
                    OP_SUB:  res_d = a_q - b_q;
                    OP_AND:  res_d = a_q & b_q;
                    OP_OR:   res_d = a_q | b_q;
                    OP_XOR:  res_d = a_q ^ b_q;
                    OP_SLT:  res_d[0] = ($signed(a_q) < $signed(b_q));
                    OP_ADDI, OP_LW, OP_SW: res_d = a_q + imm4_d;
                    OP_BEQ: begin
                        if (a_q == b_q) npc_d = pc_plus_1 + imm4_a;
                    end
                    OP_JMP:  npc_d = jmp_pc;
                    OP_BL: begin
                        res_d = DATA_W'(pc_plus_1);
                        npc_d = pc_plus_1 + imm8_a;
                    end
                    OP_BR:   npc_d = ADDR_W'(a_q);
`ifdef CPU_MUL_EN
                    OP_MUL:  res_d = mul_lo;
`endif
                    default: res_d = '0;
                endcase
                state_d = is_mem ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (!is_store) res_d = mem_rdata;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                pc_d = npc_q;
                if (wr_en) regs_d[wr_idx] = res_q;
                state_d = S_FETCH;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == S_FETCH) begin
            mem_req  = 1'b1;
            mem_addr = pc_q;
        end else if (state_q == S_MEM) begin
            mem_req  = 1'b1;
            mem_we   = is_store;
            mem_addr = ADDR_W'(res_q);
            if (is_store) mem_wdata = b_q;
        end
    end

    assign instr_retired = (state_q == S_WB);
    assign halted        = (state_q == S_HALTED);
    assign pc_out        = pc_q;

    always_ff @(posedge clk) begin
        if (pc_reset) begin
            state_q     <= S_IDLE;
            idle_wait_q <= 1'b1;
            pc_q        <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            npc_q       <= '0;
            regs_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            idle_wait_q <= idle_wait_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            npc_q       <= npc_d;
            regs_q      <= regs_d;
        end
    end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed-program bench for cpu_multicycle: a memory responder with programmable ack delay,
// bus-read trace and retire-cycle log; expected results are hand-computed per program.
module tb_cpu_multicycle;

    logic        clk = 1'b0;
    logic        pc_reset = 1'b1;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ack = 1'b0;
    logic        instr_retired, halted;
    logic [15:0] pc_out;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rel_cyc = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    bit blk_en = 1'b0;
    logic [15:0] blk_addr = 16'h0000;
    bit force_ack = 1'b0;

    logic [15:0] mem [0:65535];
    int          ret_cyc [$];
    logic [15:0] rtrace [$];

    cpu_multicycle #(.DATA_W(16), .ADDR_W(16), .NREGS(16)) dut (
        .clk           (clk),
        .pc_reset      (pc_reset),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .instr_retired (instr_retired),
        .halted        (halted),
        .pc_out        (pc_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Responder: acks after ack_delay wait cycles; reads are logged in order.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 16'hF000;
        end else if (mem_req === 1'b1 && !(blk_en && mem_addr == blk_addr)) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                if (mem_we) mem[mem_addr] = mem_wdata;
                else        rtrace.push_back(mem_addr);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(negedge clk) if (instr_retired === 1'b1) ret_cyc.push_back(cyc);

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 16'hF000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        pc_reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        pc_reset = 1'b0;
        ret_cyc.delete();
        rtrace.delete();
        rel_cyc = cyc;
    endtask

    task automatic wait_halt(output bit ok);
        int n = 0;
        while (halted !== 1'b1 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = (halted === 1'b1);
    endtask

    task automatic test_reset();
        pc_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({mem_req, mem_we, instr_retired, halted} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl: req/we/ret/halt=%b, required 0000", {mem_req, mem_we, instr_retired, halted});
        end
        tests++;
        if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || pc_out !== 16'h0) begin
            fails++;
            $display("FAIL reset_bus: addr=%h wdata=%h pc=%h, required 0000 0000 0000", mem_addr, mem_wdata, pc_out);
        end
        @(negedge clk);
        pc_reset = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: mem_req=%b one cycle after release, required 0", mem_req);
        end
        @(posedge clk);
        #1;
        tests++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0) begin
            fails++;
            $display("FAIL reset_first_fetch: req=%b we=%b addr=%h, required 1 0 0000", mem_req, mem_we, mem_addr);
        end
    endtask

    task automatic test_alu();
        logic [15:0] prog [15] = '{16'h6015, 16'h602D, 16'h0123, 16'h5214, 16'h1125, 16'h2126, 16'h3127,
                                   16'h4128, 16'h803F, 16'h804E, 16'h805D, 16'h806C, 16'h807B, 16'h808A, 16'hF000};
        logic [15:0] ea [6] = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFB, 16'hFFFA};
        logic [15:0] ev [6] = '{16'h0002, 16'h0001, 16'h0008, 16'h0005, 16'hFFFD, 16'hFFF8};
        bit ok;
        int reqs = 0;
        clear_mem();
        for (int i = 0; i < 15; i++) mem[i] = prog[i];
        ack_delay = 0;
        do_reset();
        wait_halt(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL alu_halt: halted=%b, required 1", halted);
        end
        tests++;
        if (ret_cyc.size() != 14) begin
            fails++;
            $display("FAIL alu_retires: %0d pulses, required 14", ret_cyc.size());
        end
        tests++;
        if (ret_cyc[0] - rel_cyc != 5) begin
            fails++;
            $display("FAIL alu_first_latency: %0d cycles, required 5", ret_cyc[0] - rel_cyc);
        end
        tests++;
        if (ret_cyc[1] - ret_cyc[0] != 4 || ret_cyc[3] - ret_cyc[2] != 4 || ret_cyc[7] - ret_cyc[6] != 4) begin
            fails++;
            $display("FAIL alu_latency: %0d %0d %0d cycles, required 4 4 4",
                     ret_cyc[1] - ret_cyc[0], ret_cyc[3] - ret_cyc[2], ret_cyc[7] - ret_cyc[6]);
        end
        tests++;
        if (ret_cyc[9] - ret_cyc[8] != 5) begin
            fails++;
            $display("FAIL sw_latency: %0d cycles, required 5", ret_cyc[9] - ret_cyc[8]);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (mem[ea[i]] !== ev[i]) begin
                fails++;
                $display("FAIL alu_result[%0d]: mem[%h]=%h, required %h", i, ea[i], mem[ea[i]], ev[i]);
            end
        end
        repeat (10) begin
            @(posedge clk);
            #1;
            if (mem_req !== 1'b0) reqs++;
        end
        tests++;
        if (reqs != 0 || halted !== 1'b1) begin
            fails++;
            $display("FAIL halt_quiet: %0d requests while halted (halted=%b), required 0 (1)", reqs, halted);
        end
    endtask

    task automatic test_mem_wait();
        logic [15:0] prog [7] = '{16'h6015, 16'h8012, 16'h7052, 16'h805F, 16'h7772, 16'h807E, 16'hF000};
        bit ok;
        bit stable = 1'b1;
        int held = 0;
        int n = 0;
        clear_mem();
        mem[0] = 16'hA100;
        for (int i = 0; i < 7; i++) mem[16'h100 + i] = prog[i];
        ack_delay = 3;
        do_reset();
        while (!(mem_req === 1'b1 && mem_we === 1'b1) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        while (mem_req === 1'b1 && mem_we === 1'b1 && held < 20) begin
            if (mem_addr !== 16'h0002 || mem_wdata !== 16'h0005) stable = 1'b0;
            held++;
            @(posedge clk);
            #1;
        end
        tests++;
        if (!stable) begin
            fails++;
            $display("FAIL sw_stable: addr=%h wdata=%h not held at 0002/0005", mem_addr, mem_wdata);
        end
        tests++;
        if (held != 4) begin
            fails++;
            $display("FAIL sw_req_cycles: %0d cycles of request, required 4", held);
        end
        wait_halt(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL mem_halt: halted=%b, required 1", halted);
        end
        tests++;
        if (ret_cyc[2] - ret_cyc[1] != 11 || ret_cyc[3] - ret_cyc[2] != 11) begin
            fails++;
            $display("FAIL mem_wait_latency: sw %0d lw %0d cycles, required 11 11",
                     ret_cyc[2] - ret_cyc[1], ret_cyc[3] - ret_cyc[2]);
        end
        tests++;
        if (mem[16'h0002] !== 16'h0005 || mem[16'hFFFF] !== 16'h0005) begin
            fails++;
            $display("FAIL lw_value: mem[2]=%h R5=%h, required 0005 0005", mem[16'h0002], mem[16'hFFFF]);
        end
        tests++;
        if (mem[16'hFFFE] !== 16'h0005) begin
            fails++;
            $display("FAIL lw_rt_eq_rs: R7=%h, required 0005", mem[16'hFFFE]);
        end
    endtask

    task automatic test_flow();
        logic [15:0] exp_tr [15] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0007, 16'h0014, 16'h000D,
                                     16'h000E, 16'h0015, 16'hFFF8, 16'h0016, 16'h1234, 16'h10FF, 16'h1100};
        bit ok;
        clear_mem();
        mem[0] = 16'h6011; mem[1] = 16'h9103; mem[2] = 16'hE000; mem[3] = 16'hE000;
        mem[4] = 16'h9112; mem[5] = 16'h6091; mem[6] = 16'h6091; mem[7] = 16'hA014;
        mem[16'h14] = 16'hBF8F; mem[16'h0D] = 16'h80FF; mem[16'h0E] = 16'hCF00;
        mem[16'h15] = 16'h70A8; mem[16'h16] = 16'hCA00; mem[16'hFFF8] = 16'h1234;
        mem[16'h1234] = 16'hA0FF; mem[16'h10FF] = 16'h809E; mem[16'h1100] = 16'hF000;
        ack_delay = 0;
        do_reset();
        wait_halt(ok);
        tests++;
        if (!ok || rtrace.size() != 15) begin
            fails++;
            $display("FAIL flow_trace_len: halted=%b reads=%0d, required 1 15", halted, rtrace.size());
        end
        for (int i = 0; i < 15; i++) begin
            tests++;
            if (rtrace[i] !== exp_tr[i]) begin
                fails++;
                $display("FAIL flow_read[%0d]: addr=%h, required %h", i, rtrace[i], exp_tr[i]);
            end
        end
        tests++;
        if (mem[16'hFFFF] !== 16'h0015) begin
            fails++;
            $display("FAIL bl_link: R15=%h, required 0015", mem[16'hFFFF]);
        end
        tests++;
        if (mem[16'hFFFE] !== 16'h0000) begin
            fails++;
            $display("FAIL beq_skip: R9=%h, required 0000", mem[16'hFFFE]);
        end
    endtask

    task automatic test_pc_wrap();
        logic [15:0] exp_tr [4] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0050};
        bit ok;
        clear_mem();
        mem[0] = 16'h601F; mem[1] = 16'hC100; mem[16'hFFFF] = 16'hA050; mem[16'h50] = 16'hF000;
        ack_delay = 0;
        do_reset();
        wait_halt(ok);
        tests++;
        if (!ok || rtrace.size() != 4) begin
            fails++;
            $display("FAIL wrap_trace_len: halted=%b reads=%0d, required 1 4", halted, rtrace.size());
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rtrace[i] !== exp_tr[i]) begin
                fails++;
                $display("FAIL wrap_read[%0d]: addr=%h, required %h", i, rtrace[i], exp_tr[i]);
            end
        end
    endtask

    task automatic test_halt_reset();
        logic [15:0] exp_tr [4] = '{16'h0000, 16'hFFFF, 16'h0001, 16'h0002};
        bit ok;
        int n = 0;
        clear_mem();
        mem[0] = 16'h701F; mem[1] = 16'h801E; mem[2] = 16'hF000; mem[16'hFFFF] = 16'h0055;
        ack_delay = 0;
        blk_en = 1'b1;
        blk_addr = 16'hFFFF;
        do_reset();
        while (!(mem_req === 1'b1 && mem_addr === 16'hFFFF) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 16'hFFFF) begin
            fails++;
            $display("FAIL lw_stall: req=%b addr=%h, required 1 ffff", mem_req, mem_addr);
        end
        @(negedge clk);
        pc_reset = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || pc_out !== 16'h0) begin
            fails++;
            $display("FAIL reset_abandon: req=%b we=%b pc=%h, required 0 0 0000", mem_req, mem_we, pc_out);
        end
        force_ack = 1'b1;
        blk_en = 1'b0;
        pc_reset = 1'b0;
        ret_cyc.delete();
        rtrace.delete();
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        tests++;
        if (mem_req !== 1'b0 || pc_out !== 16'h0) begin
            fails++;
            $display("FAIL late_ack_ignored: req=%b pc=%h, required 0 0000", mem_req, pc_out);
        end
        @(posedge clk);
        #1;
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0) begin
            fails++;
            $display("FAIL refetch: req=%b addr=%h, required 1 0000", mem_req, mem_addr);
        end
        wait_halt(ok);
        tests++;
        if (!ok || ret_cyc.size() != 2 || rtrace.size() != 4) begin
            fails++;
            $display("FAIL rerun: halted=%b retires=%0d reads=%0d, required 1 2 4", halted, ret_cyc.size(), rtrace.size());
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rtrace[i] !== exp_tr[i]) begin
                fails++;
                $display("FAIL rerun_read[%0d]: addr=%h, required %h", i, rtrace[i], exp_tr[i]);
            end
        end
        tests++;
        if (mem[16'hFFFE] !== 16'h0055) begin
            fails++;
            $display("FAIL rerun_lw: mem[fffe]=%h, required 0055", mem[16'hFFFE]);
        end
    endtask

    task automatic test_mul();
        logic [15:0] prog [6] = '{16'h6017, 16'h6026, 16'h6031, 16'hD123, 16'h803F, 16'hF000};
        logic [15:0] exp_r3;
        bit ok;
`ifdef CPU_MUL_EN
        exp_r3 = 16'd42;
`else
        exp_r3 = 16'd1;
`endif
        clear_mem();
        for (int i = 0; i < 6; i++) mem[i] = prog[i];
        ack_delay = 0;
        do_reset();
        wait_halt(ok);
        tests++;
        if (!ok || ret_cyc.size() != 5 || rtrace.size() != 6) begin
            fails++;
            $display("FAIL mul_run: halted=%b retires=%0d reads=%0d, required 1 5 6", halted, ret_cyc.size(), rtrace.size());
        end
        tests++;
        if (ret_cyc[3] - ret_cyc[2] != 4) begin
            fails++;
            $display("FAIL mul_latency: %0d cycles, required 4", ret_cyc[3] - ret_cyc[2]);
        end
        tests++;
        if (mem[16'hFFFF] !== exp_r3) begin
            fails++;
            $display("FAIL mul_result: R3=%h, required %h", mem[16'hFFFF], exp_r3);
        end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_alu();
        test_mem_wait();
        test_flow();
        test_pc_wrap();
        test_halt_reset();
        test_mul();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
